sum_accumulator: RTL and testbench

Downstream stage of the parameterised adder: consumes its WIDTH+1-bit `sum` stream over a valid/ready handshake and adds COUNT consecutive accepted samples into an ACC_W-bit total. It presents the total with an overflow flag on an output valid/ready handshake, then restarts. It sits between the adder and any checker or result sink.

---
 rtl/adder_pkg.sv | 14 +
 rtl/acc_add_sat.sv | 27 ++
 rtl/sum_accumulator.sv | 115 +++++++++++
 tb/tb_sum_accumulator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder pipeline: default widths and the
// accumulator state encoding.
package adder_pkg;

  localparam int unsigned DEF_WIDTH = 6;
  localparam int unsigned DEF_COUNT = 8;
  localparam int unsigned DEF_ACC_W = 10;

  typedef enum logic {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } acc_state_e;

endpackage

// File: rtl/acc_add_sat.sv
// Combinational ACC_W-bit adder returning the next accumulator value and
// the carry out of the top bit.
// Build option: SUM_ACCUMULATOR_SATURATE_EN clamps the sum to all-ones on
// carry; without it the sum wraps modulo 2^ACC_W.
module acc_add_sat #(
  parameter int unsigned ACC_W = 10
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum_c,
  output logic             carry_c
);

  logic [ACC_W:0] full;

  // Widen by one bit so the carry falls out of the add directly.
  always_comb begin
    full    = {1'b0, a} + {1'b0, b};
    carry_c = full[ACC_W];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
    sum_c   = carry_c ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    sum_c   = full[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT accepted adder samples into an ACC_W-bit total and
// presents it with a sticky overflow flag on a valid/ready handshake.
// Build option: SUM_ACCUMULATOR_SATURATE_EN selects clamping instead of wrap.
module sum_accumulator
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned COUNT = DEF_COUNT,
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int unsigned CNT_W = $clog2(COUNT + 1);

  acc_state_e       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [ACC_W-1:0] out_acc_nxt;
  logic             out_ovf_nxt;

  logic [ACC_W-1:0] add_b;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             accept;
  logic             last;

  assign add_b = ACC_W'(in_sum);

  acc_add_sat #(
    .ACC_W (ACC_W)
  ) u_add (
    .a       (acc),
    .b       (add_b),
    .sum_c   (add_sum),
    .carry_c (add_carry)
  );

  // Handshake flags come from state only; clear and reset block intake.
  assign in_ready  = rstn & (state == ST_ACC) & ~clear;
  assign out_valid = (state == ST_OUT);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt == CNT_W'(COUNT - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_ACC;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      out_acc <= '0;
      out_ovf <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      ovf     <= ovf_nxt;
      out_acc <= out_acc_nxt;
      out_ovf <= out_ovf_nxt;
    end
  end

  // Next-state and datapath update for collect / present.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf;
    out_acc_nxt = out_acc;
    out_ovf_nxt = out_ovf;
    if (clear) begin
      state_nxt = ST_ACC;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (last) begin
              out_acc_nxt = add_sum;
              out_ovf_nxt = ovf | add_carry;
              acc_nxt     = '0;
              cnt_nxt     = '0;
              state_nxt   = ST_OUT;
            end else begin
              acc_nxt = add_sum;
              cnt_nxt = cnt + CNT_W'(1);
              ovf_nxt = ovf | add_carry;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_nxt = ST_ACC;
            ovf_nxt   = 1'b0;
          end
        end
        default: state_nxt = ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: a default instance (ACC_W=10) and an
// ACC_W=8 instance share stimulus; results are popped at each output handshake.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] in_sum = '0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, out_ovf;
  logic [9:0] out_acc;
  logic       in_ready8, out_valid8, out_ovf8;
  logic [7:0] out_acc8;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int acc10;
    int ovf10;
    int acc8;
    int ovf8;
  } exp_t;
  exp_t sb[$];

`ifdef SUM_ACCUMULATOR_SATURATE_EN
  localparam int E8_126 = 255;
  localparam int E8_100 = 255;
`else
  localparam int E8_126 = 240;
  localparam int E8_100 = 32;
`endif

  always #5 clk = ~clk;

  sum_accumulator u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  sum_accumulator #(.WIDTH(6), .COUNT(8), .ACC_W(8)) u_dut8 (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .in_sum    (in_sum),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_acc   (out_acc8),
    .out_ovf   (out_ovf8)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic push(input int a10, input int o10, input int a8, input int o8);
    exp_t e;
    e.acc10 = a10; e.ovf10 = o10; e.acc8 = a8; e.ovf8 = o8;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Offer one sample and hold it until accepted (bounded wait).
  task automatic send(input int v);
    int waited = 0;
    in_valid = 1'b1;
    in_sum   = 7'(v);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 50) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare every completed output handshake against the scoreboard.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_acc", int'(out_acc), e.acc10);
        check("out_ovf", int'(out_ovf), e.ovf10);
        check("out_valid8", int'(out_valid8), 1);
        check("out_acc8", int'(out_acc8), e.acc8);
        check("out_ovf8", int'(out_ovf8), e.ovf8);
      end
    end
  end

  initial begin
    // Reset state
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_acc", int'(out_acc), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    check("rst_in_ready", int'(in_ready), 0);
    idle(2);
    rstn = 1'b1;
    #1;
    check("post_rst_in_ready", int'(in_ready), 1);

    // 0,2,...,14 back-to-back -> 56
    for (int i = 0; i < 8; i++) begin
      send(2 * i);
      if (i == 6) check("valid_before_last", int'(out_valid), 0);
    end
    check("valid_after_last", int'(out_valid), 1);
    check("in_ready_in_out", int'(in_ready), 0);
    push(56, 0, 56, 0);

    // 8x126 with random gaps -> 1008; ACC_W=8 overflows
    for (int i = 0; i < 8; i++) begin
      idle($urandom_range(0, 3));
      send(126);
    end
    push(1008, 0, E8_126, 1);

    // Stall in OUT for 5 cycles with a sample offered
    idle(2);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(100);
    push(800, 0, E8_100, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sum   = 7'd77;
      @(negedge clk);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_out_acc", int'(out_acc), 800);
      check("stall_in_ready", int'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(2);
    push(16, 0, 16, 0);

    // Clear after 4 samples, with a sample offered
    for (int i = 0; i < 4; i++) send(5);
    in_valid = 1'b1;
    in_sum   = 7'd50;
    clear    = 1'b1;
    @(negedge clk);
    check("clear_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) send(1);
    push(8, 0, 8, 0);
    idle(2);

    // Reset mid-window
    for (int i = 0; i < 5; i++) send(9);
    rstn = 1'b0;
    #1;
    check("mid_rst_out_acc", int'(out_acc), 0);
    check("mid_rst_out_acc8", int'(out_acc8), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    idle(2);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) send(3);
    push(24, 0, 24, 0);

    // Drain scoreboard (bounded)
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    #1;
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
